// File: rtl/intc_pkg.sv
// Shared constants, FSM state type and vector helper for the interrupt controller.
package intc_pkg;

  localparam logic [31:0] VEC_BASE = 32'h0000_0100;
  localparam logic [31:0] NMI_VEC  = 32'h0000_0200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SERVICE,
    ST_NMI_ASSERT,
    ST_NMI_SERVICE
  } intc_state_t;

  // Each maskable source owns an 8-byte slot above VEC_BASE.
  function automatic logic [31:0] vec_of(input logic [31:0] id);
    return VEC_BASE + (id << 3);
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority first-one encoder: lowest set index wins.
module intc_prio_enc #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (req[i] && !valid) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller: fixed-priority maskable sources plus a
// non-maskable line that may nest on top of an active maskable handler.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               cpu_respond,
  input  logic               eoi,
  output logic               interrupt_r,
  output logic               NON_maskable_interrupt,
  output logic [31:0]        vector_addr,
  output logic [NUM_IRQ-1:0] pending,
  output logic [ID_W-1:0]    in_service_id,
  output logic               in_service
);

  intc_state_t state, state_next;

  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] pend_clr;
  logic               nmi_prev;
  logic               nmi_pending;
  logic               nmi_rise;
  logic               nest;
  logic               busy;
  logic [ID_W-1:0]    cur_id;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               eoi_ok;
  logic               take_irq;
  logic               ack_irq;
  logic               ack_nmi;
  logic               done_irq;
  logic               nest_enter;
  logic               nest_exit;

  assign irq_rise = irq_in & ~irq_prev;
  assign nmi_rise = nmi_in & ~nmi_prev;
  assign eligible = pend_q & ~mask_q;
  assign eoi_ok   = eoi & ~cpu_respond;

  intc_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .id    (win_id),
    .valid (win_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (nmi_pending) begin
          state_next = ST_NMI_ASSERT;
        end else if (win_valid) begin
          state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (cpu_respond) begin
          state_next = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        // A completing handler is honoured before nesting; the NMI is then
        // taken from IDLE one cycle later, so no eoi is ever lost.
        if (eoi_ok) begin
          state_next = ST_IDLE;
        end else if (nmi_pending) begin
          state_next = ST_NMI_ASSERT;
        end
      end
      ST_NMI_ASSERT: begin
        if (cpu_respond) begin
          state_next = ST_NMI_SERVICE;
        end
      end
      ST_NMI_SERVICE: begin
        if (eoi_ok) begin
          state_next = nest ? ST_SERVICE : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign take_irq   = (state == ST_IDLE) && !nmi_pending && win_valid;
  assign ack_irq    = (state == ST_ASSERT) && cpu_respond;
  assign ack_nmi    = (state == ST_NMI_ASSERT) && cpu_respond;
  assign done_irq   = (state == ST_SERVICE) && eoi_ok;
  assign nest_enter = (state == ST_SERVICE) && !eoi_ok && nmi_pending;
  assign nest_exit  = (state == ST_NMI_SERVICE) && eoi_ok;
  assign pend_clr   = ack_irq ? (NUM_IRQ'(1) << cur_id) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev    <= '0;
      nmi_prev    <= 1'b0;
      pend_q      <= '0;
      nmi_pending <= 1'b0;
      mask_q      <= '1;
      cur_id      <= '0;
      busy        <= 1'b0;
      nest        <= 1'b0;
    end else begin
      irq_prev    <= irq_in;
      nmi_prev    <= nmi_in;
      // A fresh edge overrides a simultaneous clear.
      pend_q      <= (pend_q & ~pend_clr) | irq_rise;
      nmi_pending <= (nmi_pending & ~ack_nmi) | nmi_rise;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      if (take_irq) begin
        cur_id <= win_id;
      end
      if (ack_irq) begin
        busy <= 1'b1;
      end else if (done_irq) begin
        busy <= 1'b0;
      end
      if (nest_enter) begin
        nest <= 1'b1;
      end else if (nest_exit) begin
        nest <= 1'b0;
      end
    end
  end

  always_comb begin
    interrupt_r            = (state == ST_ASSERT);
    NON_maskable_interrupt = (state == ST_NMI_ASSERT);
    if ((state == ST_NMI_ASSERT) || (state == ST_NMI_SERVICE)) begin
      vector_addr = NMI_VEC;
    end else begin
      vector_addr = vec_of(32'(cur_id));
    end
    pending       = pend_q;
    in_service_id = cur_id;
    in_service    = busy;
  end

endmodule
